// File: rtl/tri_frag_iterator.sv
// tri_frag_iterator: takes one triangle as three signed pixel-coordinate
// vertices, computes its screen-clipped bounding box, and walks every pixel
// of that box, emitting one fragment per downstream handshake. The walk is
// either raster order or serpentine order.
// Boxes that are empty after clipping produce no fragments. They are
// reported with a single-cycle tri_skipped pulse.
module tri_frag_iterator #(
    parameter int COORD_W    = 12,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter bit SERPENTINE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      nd,
    output logic                      rfd,
    input  logic signed [COORD_W-1:0] v1_posX,
    input  logic signed [COORD_W-1:0] v1_posY,
    input  logic signed [COORD_W-1:0] v2_posX,
    input  logic signed [COORD_W-1:0] v2_posY,
    input  logic signed [COORD_W-1:0] v3_posX,
    input  logic signed [COORD_W-1:0] v3_posY,
    input  logic                      ds_rfd,
    output logic                      rdy,
    output logic        [COORD_W-1:0] frag_posX,
    output logic        [COORD_W-1:0] frag_posY,
    output logic                      frag_first,
    output logic                      frag_last,
    output logic                      tri_skipped
);

    // The clip limits are used as positive signed numbers, so they must
    // leave the sign bit of a coordinate free.
    if (SCREEN_W < 1 || SCREEN_H < 1 ||
        (SCREEN_W - 1) >= (1 << (COORD_W - 1)) ||
        (SCREEN_H - 1) >= (1 << (COORD_W - 1))) begin : g_bad_screen
        $error("tri_frag_iterator: SCREEN_W-1/SCREEN_H-1 must fit in COORD_W-1 bits");
    end

    localparam logic signed [COORD_W-1:0] LIM_X = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] LIM_Y = COORD_W'(SCREEN_H - 1);
    localparam logic signed [COORD_W-1:0] ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE,
        BOX,
        CHECK,
        ITER
    } state_t;

    state_t state_q;

    // Registered vertices. The upstream stage may drop them after the accept edge.
    logic signed [COORD_W-1:0] v1x_q, v1y_q, v2x_q, v2y_q, v3x_q, v3y_q;

    // Clipped bounding box. These are signed so that a fully off-screen box
    // shows up as max < min.
    logic signed [COORD_W-1:0] minX_q, maxX_q, minY_q, maxY_q;

    // Walk counters. They double as the fragment position outputs.
    logic [COORD_W-1:0] x_q, y_q;
    logic               rowOdd_q;

    // Registered handshake and flag outputs.
    logic rfd_q, rdy_q, first_q, last_q, skipped_q;

    // Bounding-box candidates computed from the registered vertices.
    logic signed [COORD_W-1:0] boxMinX_d, boxMaxX_d, boxMinY_d, boxMaxY_d;
    logic                      boxEmpty_d;

    // Position of the fragment that follows the current one.
    logic [COORD_W-1:0] minXu, maxXu, minYu, maxYu;
    logic [COORD_W-1:0] x_d, y_d;
    logic               rowOdd_d, last_d, atRowEnd, nextAtRowEnd;

    function automatic logic signed [COORD_W-1:0] smin(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic signed [COORD_W-1:0] smax(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Clip the vertex extents to the screen. An empty result means no fragments.
    always_comb begin
        boxMinX_d  = smax(smin(smin(v1x_q, v2x_q), v3x_q), ZERO);
        boxMaxX_d  = smin(smax(smax(v1x_q, v2x_q), v3x_q), LIM_X);
        boxMinY_d  = smax(smin(smin(v1y_q, v2y_q), v3y_q), ZERO);
        boxMaxY_d  = smin(smax(smax(v1y_q, v2y_q), v3y_q), LIM_Y);
        boxEmpty_d = (boxMaxX_d < boxMinX_d) || (boxMaxY_d < boxMinY_d);
    end

    // Once a box is accepted as non-empty, its bounds are non-negative and
    // on screen. From then on they are compared as plain unsigned counters.
    assign minXu = minX_q;
    assign maxXu = maxX_q;
    assign minYu = minY_q;
    assign maxYu = maxY_q;

    // Step the walk. Serpentine odd rows run right-to-left. A serpentine row
    // change keeps X where it is, while raster order snaps X back to minX.
    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        rowOdd_d     = rowOdd_q;
        atRowEnd     = (SERPENTINE && rowOdd_q) ? (x_q == minXu) : (x_q == maxXu);
        if (!atRowEnd) begin
            x_d = (SERPENTINE && rowOdd_q) ? (x_q - 1'b1) : (x_q + 1'b1);
        end else begin
            y_d      = y_q + 1'b1;
            rowOdd_d = ~rowOdd_q;
            x_d      = SERPENTINE ? x_q : minXu;
        end
        nextAtRowEnd = (SERPENTINE && rowOdd_d) ? (x_d == minXu) : (x_d == maxXu);
        last_d       = nextAtRowEnd && (y_d == maxYu);
    end

    // Main control FSM. It also owns all registered outputs and the walk state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            v1x_q     <= '0;
            v1y_q     <= '0;
            v2x_q     <= '0;
            v2y_q     <= '0;
            v3x_q     <= '0;
            v3y_q     <= '0;
            minX_q    <= '0;
            maxX_q    <= '0;
            minY_q    <= '0;
            maxY_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            rowOdd_q  <= 1'b0;
            rfd_q     <= 1'b0;
            rdy_q     <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            skipped_q <= 1'b0;
        end else begin
            skipped_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rfd_q <= 1'b1;
                    if (nd && rfd_q) begin
                        v1x_q   <= v1_posX;
                        v1y_q   <= v1_posY;
                        v2x_q   <= v2_posX;
                        v2y_q   <= v2_posY;
                        v3x_q   <= v3_posX;
                        v3y_q   <= v3_posY;
                        rfd_q   <= 1'b0;
                        state_q <= BOX;
                    end
                end
                BOX: begin
                    minX_q    <= boxMinX_d;
                    maxX_q    <= boxMaxX_d;
                    minY_q    <= boxMinY_d;
                    maxY_q    <= boxMaxY_d;
                    skipped_q <= boxEmpty_d;
                    state_q   <= CHECK;
                end
                CHECK: begin
                    if (skipped_q) begin
                        rfd_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        x_q      <= minXu;
                        y_q      <= minYu;
                        rowOdd_q <= 1'b0;
                        rdy_q    <= 1'b1;
                        first_q  <= 1'b1;
                        last_q   <= (minX_q == maxX_q) && (minY_q == maxY_q);
                        state_q  <= ITER;
                    end
                end
                ITER: begin
                    if (ds_rfd) begin
                        if (last_q) begin
                            x_q      <= '0;
                            y_q      <= '0;
                            rowOdd_q <= 1'b0;
                            rdy_q    <= 1'b0;
                            first_q  <= 1'b0;
                            last_q   <= 1'b0;
                            rfd_q    <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            x_q      <= x_d;
                            y_q      <= y_d;
                            rowOdd_q <= rowOdd_d;
                            first_q  <= 1'b0;
                            last_q   <= last_d;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rfd         = rfd_q;
    assign rdy         = rdy_q;
    assign frag_posX   = x_q;
    assign frag_posY   = y_q;
    assign frag_first  = first_q;
    assign frag_last   = last_q;
    assign tri_skipped = skipped_q;

endmodule
